// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Package     : serial_arith_pkg
// Description : Shared definitions for the bit-serial arithmetic blocks
//               (adder, subtractor): control state encoding, borrow/carry
//               state constants and the bit-counter width helper.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

  // Control state of a serial arithmetic operation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // Borrow (subtractor) / carry (adder) state.
  localparam logic G = 1'b0;  // no borrow / no carry
  localparam logic H = 1'b1;  // borrow / carry pending

  // Counter must be able to hold N, so it needs clog2(N+1) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Interface   : serial_subtractor_if
// Description : Start/busy/done handshake and operand/result bus of the
//               bit-serial subtractor.
// Signals     : start, x, y       (controller -> subtractor)
//               z, borrow_out,
//               busy, done        (subtractor -> controller)
// Modports    : master (controller side), slave (subtractor side)
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic [N-1:0] z;
  logic         borrow_out;
  logic         busy;
  logic         done;

  modport master (output start, x, y, input z, borrow_out, busy, done);
  modport slave  (input start, x, y, output z, borrow_out, busy, done);
endinterface
`default_nettype wire

// File: rtl/shift_reg_lr.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_lr
// Description : N-bit right-shift register with parallel load, serial input
//               at the MSB and serial output at the LSB. Load has priority
//               over shift.
// Ports       : clock, reset      clock / synchronous active-high reset
//               load, load_val    parallel load strobe and value
//               shift, serial_in  shift enable and MSB fill bit
//               q                 current contents
//               shift_val         contents after the next shift
//               serial_out        current LSB
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_lr #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         shift,
  input  logic         serial_in,
  output logic [N-1:0] q,
  output logic [N-1:0] shift_val,
  output logic         serial_out
);

  // A 1-bit register has nothing to keep on a shift.
  generate
    if (N == 1) begin : g_single
      assign shift_val = serial_in;
    end else begin : g_multi
      assign shift_val = {serial_in, q[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= shift_val;
    end
  end

  assign serial_out = q[0];

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor, z = x - y mod 2^N,
//               LSB first, one bit per clock, with start/busy/done handshake.
// Ports       : clock  rising-edge clock
//               reset  synchronous active-high reset
//               bus    serial_subtractor_if.slave (start, x, y, z,
//                      borrow_out, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clock,
  input  logic              reset,
  serial_subtractor_if.slave bus
);

  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  ctrl_state_t   state;
  ctrl_state_t   state_nx;
  logic          load;
  logic          shift;
  logic          borrow;
  logic          borrow_nx;
  logic          diff;
  logic          xb;
  logic          yb;
  logic [CW-1:0] cnt;
  logic          last;
  logic [N-1:0]  z_reg;
  logic          borrow_out_reg;

  logic [N-1:0]  x_q;
  logic [N-1:0]  x_nx;
  logic [N-1:0]  y_q;
  logic [N-1:0]  y_nx;
  logic [N-1:0]  res_q;
  logic [N-1:0]  res_nx;
  logic          res_lsb;

  // Operand registers drain LSB first, zero-filled from the top.
  shift_reg_lr #(.N(N)) u_x_sr (
    .clock(clock), .reset(reset), .load(load), .load_val(bus.x),
    .shift(shift), .serial_in(1'b0), .q(x_q), .shift_val(x_nx),
    .serial_out(xb)
  );

  shift_reg_lr #(.N(N)) u_y_sr (
    .clock(clock), .reset(reset), .load(load), .load_val(bus.y),
    .shift(shift), .serial_in(1'b0), .q(y_q), .shift_val(y_nx),
    .serial_out(yb)
  );

  // Difference bits enter at the MSB, so after N shifts bit 0 sits at bit 0.
  shift_reg_lr #(.N(N)) u_res_sr (
    .clock(clock), .reset(reset), .load(load), .load_val('0),
    .shift(shift), .serial_in(diff), .q(res_q), .shift_val(res_nx),
    .serial_out(res_lsb)
  );

  assign diff      = xb ^ yb ^ borrow;
  assign borrow_nx = (~xb & yb) | (~(xb ^ yb) & borrow);
  assign last      = (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      borrow         <= G;
      cnt            <= '0;
      z_reg          <= '0;
      borrow_out_reg <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        borrow <= G;
        cnt    <= '0;
      end else if (shift) begin
        borrow <= borrow_nx;
        cnt    <= cnt + CW'(1);
        // res_nx already contains this edge's difference bit.
        if (last) begin
          z_reg          <= res_nx;
          borrow_out_reg <= borrow_nx;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.z          = z_reg;
  assign bus.borrow_out = borrow_out_reg;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);

endmodule
`default_nettype wire
